// File: rtl/calc_seq.sv
// Sequential calculator: single-cycle logic/arith ops, W-step shift-add multiply and restoring divide.
// Define CALC_DIV_EN to build the divider; otherwise f=100 completes at once with Err=1.
module calc_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [2:0]   f,
  output logic         Done,
  output logic         Busy,
  output logic [W-1:0] Out_H,
  output logic [W-1:0] Out_L,
  output logic         Err
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef CALC_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;   // multiplicand, or divisor
  logic [W-1:0]  acc_hi;  // partial product high half, or running remainder
  logic [W-1:0]  acc_lo;  // multiplier being shifted out, or dividend/quotient

  logic [W:0]    add_s, sub_s;
  logic [W-1:0]  sc_h, sc_l;
  logic          sc_err, go_mul;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi, mul_lo;

  assign add_s  = {1'b0, x} + {1'b0, y};
  assign sub_s  = {1'b0, x} - {1'b0, y};
  assign go_mul = (f == 3'b101);

  always_comb begin
    sc_h   = '0;
    sc_l   = '0;
    sc_err = 1'b0;
    case (f)
      3'b000: begin sc_l = add_s[W-1:0]; sc_h = W'(add_s[W]); end
      3'b001: begin sc_l = sub_s[W-1:0]; sc_h = W'(sub_s[W]); end
      3'b010: sc_l = x & y;
      3'b011: sc_l = x ^ y;
      3'b100: sc_err = 1'b1;  // only reached when no iterative divide is started
      3'b101: sc_l = '0;
      3'b110: sc_l = x;
      3'b111: sc_l = y;
      default: sc_l = '0;
    endcase
  end

  // One shift-add step: conditionally add, then shift {hi,lo} right by one.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_reg} : '0);
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], acc_lo[W-1:1]};

`ifdef CALC_DIV_EN
  logic [W:0]   div_tr, div_diff;
  logic         div_ge, go_div;
  logic [W-1:0] div_hi, div_lo;

  assign go_div   = (f == 3'b100) && (y != '0);
  assign div_tr   = {acc_hi, acc_lo[W-1]};
  assign div_diff = div_tr - {1'b0, a_reg};
  assign div_ge   = (div_tr >= {1'b0, a_reg});
  assign div_hi   = div_ge ? div_diff[W-1:0] : div_tr[W-1:0];
  assign div_lo   = {acc_lo[W-2:0], div_ge};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      Out_H  <= '0;
      Out_L  <= '0;
      Err    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            cnt  <= '0;
            Busy <= 1'b1;
            if (go_mul) begin
              state  <= MUL;
              a_reg  <= x;
              acc_hi <= '0;
              acc_lo <= y;
`ifdef CALC_DIV_EN
            end else if (go_div) begin
              state  <= DIV;
              a_reg  <= y;
              acc_hi <= '0;
              acc_lo <= x;
`endif
            end else begin
              state <= DONE;
              Done  <= 1'b1;
              Out_H <= sc_h;
              Out_L <= sc_l;
              Err   <= sc_err;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            Done  <= 1'b1;
            Out_H <= mul_hi;
            Out_L <= mul_lo;
            Err   <= 1'b0;
          end
        end
`ifdef CALC_DIV_EN
        DIV: begin
          acc_hi <= div_hi;
          acc_lo <= div_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            Done  <= 1'b1;
            Out_H <= div_hi;
            Out_L <= div_lo;
            Err   <= 1'b0;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq at W=4, with an exhaustive operand/function sweep against a behavioural model.
module tb_calc_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, Go;
  logic [W-1:0] x, y;
  logic [2:0]   f;
  logic         Done, Busy, Err;
  logic [W-1:0] Out_H, Out_L;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .Go(Go), .x(x), .y(y), .f(f),
    .Done(Done), .Busy(Busy), .Out_H(Out_H), .Out_L(Out_L), .Err(Err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] fc,
                                output logic [W-1:0] h, output logic [W-1:0] l,
                                output logic e, output int lat);
    logic [2*W-1:0] p;
    h = '0; l = '0; e = 1'b0; lat = 1; p = '0;
    case (fc)
      3'd0: begin p = {{W{1'b0}}, a} + {{W{1'b0}}, b}; l = p[W-1:0]; h = W'(p[W]); end
      3'd1: begin l = a - b; h = (a < b) ? W'(1) : W'(0); end
      3'd2: l = a & b;
      3'd3: l = a ^ b;
      3'd4: begin
`ifdef CALC_DIV_EN
        if (b == '0) e = 1'b1;
        else begin l = a / b; h = a % b; lat = W + 1; end
`else
        e = 1'b1;
`endif
      end
      3'd5: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; h = p[2*W-1:W]; l = p[W-1:0]; lat = W + 1; end
      3'd6: l = a;
      default: l = b;
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] fc,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ee,
                        input int elat, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    x = a; y = b; f = fc; Go = 1'b1;
    @(posedge clk);
    #1 Go = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (Done) seen = 1;
    end
    chk({tag, " latency"}, k, elat);
    chk({tag, " Out_H"}, Out_H, eh);
    chk({tag, " Out_L"}, Out_L, el);
    chk({tag, " Err"}, Err, ee);
    chk({tag, " Busy"}, Busy, 1);
    @(negedge clk);
    chk({tag, " Done width"}, Done, 0);
    chk({tag, " Busy after"}, Busy, 0);
    chk({tag, " Out_L held"}, Out_L, el);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] eh, el;
    logic         ee;
    int           lat, k, pulses;
    bit           seen;

    rst = 1'b1; Go = 1'b0; x = '0; y = '0; f = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset Done", Done, 0);
    chk("reset Busy", Busy, 0);
    chk("reset Out_H", Out_H, 0);
    chk("reset Out_L", Out_L, 0);
    chk("reset Err", Err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(4'd7,  4'd9,  3'b000, 4'd1, 4'd0,  1'b0, 1, "add 7+9");
    run_op(4'd3,  4'd5,  3'b001, 4'd1, 4'hE,  1'b0, 1, "sub 3-5");
    run_op(4'd5,  4'd3,  3'b001, 4'd0, 4'd2,  1'b0, 1, "sub 5-3");
    run_op(4'd12, 4'd10, 3'b010, 4'd0, 4'd8,  1'b0, 1, "and");
    run_op(4'd12, 4'd10, 3'b011, 4'd0, 4'd6,  1'b0, 1, "xor");
    run_op(4'd11, 4'd4,  3'b110, 4'd0, 4'd11, 1'b0, 1, "pass A");
    run_op(4'd11, 4'd4,  3'b111, 4'd0, 4'd4,  1'b0, 1, "pass B");
`ifdef CALC_DIV_EN
    run_op(4'd13, 4'd4,  3'b100, 4'd1, 4'd3,  1'b0, 5, "div 13/4");
`else
    run_op(4'd13, 4'd4,  3'b100, 4'd0, 4'd0,  1'b1, 1, "div disabled");
`endif
    run_op(4'd13, 4'd0,  3'b100, 4'd0, 4'd0,  1'b1, 1, "div by zero");
    run_op(4'd6,  4'd7,  3'b000, 4'd0, 4'd13, 1'b0, 1, "Err cleared");

    // 15*15 with a stray Go pulse mid-multiply
    @(negedge clk);
    x = 4'd15; y = 4'd15; f = 3'b101; Go = 1'b1;
    @(posedge clk);
    #1 Go = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (Done) seen = 1;
      else if (k == 2) begin Go = 1'b1; x = 4'd1; y = 4'd1; f = 3'b000; end
      else if (k == 3) Go = 1'b0;
    end
    chk("mul 15*15 latency", k, W + 1);
    chk("mul 15*15 product", {Out_H, Out_L}, 8'hE1);
    pulses = 0;
    repeat (4) begin @(negedge clk); if (Done) pulses++; end
    chk("mul stray Go ignored", pulses, 0);
    chk("mul stray Go Busy", Busy, 0);
    chk("mul product held", {Out_H, Out_L}, 8'hE1);

    for (int fi = 0; fi < 8; fi++)
      for (int xi = 0; xi < 16; xi++)
        for (int yi = 0; yi < 16; yi++) begin
          model(W'(xi), W'(yi), 3'(fi), eh, el, ee, lat);
          run_op(W'(xi), W'(yi), 3'(fi), eh, el, ee, lat,
                 $sformatf("sweep f%0d x%0d y%0d", fi, xi, yi));
        end

    // Go held high: one accept every 2 cycles for single-cycle ops
    @(negedge clk);
    x = 4'd3; y = 4'd2; f = 3'b000; Go = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (Done) pulses++; end
    Go = 1'b0;
    chk("held Go add pulses", pulses, 5);
    chk("held Go add Out_L", Out_L, 4'd5);

    // Go held high: one accept every W+2 cycles for multiply
    @(negedge clk);
    x = 4'd3; y = 4'd3; f = 3'b101; Go = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (Done) pulses++; end
    Go = 1'b0;
    chk("held Go mul pulses", pulses, 2);
    chk("held Go mul product", {Out_H, Out_L}, 8'h09);
    repeat (8) @(negedge clk);

    // Asynchronous reset two cycles into a 9*9 multiply
    @(negedge clk);
    x = 4'd9; y = 4'd9; f = 3'b101; Go = 1'b1;
    @(posedge clk);
    #1 Go = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid-mul reset Busy", Busy, 0);
    chk("mid-mul reset Done", Done, 0);
    chk("mid-mul reset Out", {Out_H, Out_L}, 8'h00);
    chk("mid-mul reset Err", Err, 0);
    pulses = 0;
    repeat (2) begin @(negedge clk); if (Done) pulses++; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); if (Done) pulses++; end
    chk("mid-mul reset no Done", pulses, 0);
    chk("mid-mul reset Out held", {Out_H, Out_L}, 8'h00);
    run_op(4'd2, 4'd3, 3'b101, 4'd0, 4'd6, 1'b0, 5, "mul after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
